saturating_requantizer: RTL and testbench
=========================================

// Module: saturating_requantizer
// PURPOSE
//  Multi-channel, pipelined successor to the single-lane saturating rectifier.
//  Takes NUM_CHANNELS wide accumulator results per beat. Each lane is
//  arithmetic-right-shifted by a runtime shift with round-half-up, then
//  saturated to signed OUT_WIDTH. Sits between the neuron MAC accumulators and
//  the activation/next-layer buffers, with valid/ready flow control on both sides.
// PARAMETERS
//  IN_WIDTH      32  signed width of each input lane
//  OUT_WIDTH     16  signed width of each output lane (< IN_WIDTH)
//  NUM_CHANNELS   4  lanes per beat
//  SHIFT_WIDTH    5  width of the shift amount
//  COUNT_WIDTH   16  width of the saturation event counter
// PORTS
//  clk_in          in   1                       clock, all logic on rising edge
//  rst_n_in        in   1                       synchronous reset, active-low
//  valid_in        in   1                       input beat valid
//  ready_out       out  1                       block can accept an input beat
//  data_in         in   NUM_CHANNELS*IN_WIDTH   lane k at [k*IN_WIDTH +: IN_WIDTH]
//  shift_in        in   SHIFT_WIDTH             right-shift amount, sampled with beat
//  valid_out       out  1                       output beat valid
//  ready_in        in   1                       downstream accepts output beat
//  data_out        out  NUM_CHANNELS*OUT_WIDTH  lane k at [k*OUT_WIDTH +: OUT_WIDTH]
//  sat_flags_out   out  NUM_CHANNELS            per-lane saturated flag, aligned to data_out
//  clear_count_in  in   1                       synchronous clear of sat_count_out
//  sat_count_out   out  COUNT_WIDTH             total saturated lanes since clear
// BEHAVIOUR
//  - Clock and reset: one clock clk_in; reset rst_n_in is synchronous, active-low.
//  - Reset: valid_out=0, data_out=0, sat_flags_out=0, sat_count_out=0, both stage valids=0.
//    Reset mid-operation discards all in-flight beats.
//  - Transfer rule: a beat moves when valid && ready. valid_out and data_out stay
//    stable while valid_out=1 && ready_in=0.
//  - Pipeline: two register stages, S1 (shift+round) and S2 (saturate, output regs).
//    Latency is 2 cycles from the accept edge to valid_out when unstalled;
//    throughput is 1 beat/cycle.
//  - Stall: S2 can take a beat when !S2.v || ready_in. S1 can take a beat when
//    !S1.v || S2 can take. ready_out = !S1.v || !S2.v || ready_in (bubbles collapse).
//    The block holds at most 2 beats. No loss, no duplication, order preserved.
//  - Shift: sh = min(shift_in, IN_WIDTH-1).
//    If sh>0: r = (x + (1<<(sh-1))) >>> sh, computed in IN_WIDTH+1 bits so the
//    bias cannot wrap. If sh=0: r = x.
//  - Saturate: if r > 2^(OUT_WIDTH-1)-1, out = 0x7F..F and flag=1.
//    If r < -2^(OUT_WIDTH-1), out = 0x80..0 and flag=1.
//    Otherwise out = r[OUT_WIDTH-1:0] and flag=0.
//  - Rounding that carries past the max is still saturated
//    (e.g. 0x7FFF.80 -> 0x7FFF, flag=1).
// CONFIGURATION
//  SAT_COUNTER_EN defined:
//    - On each output handshake, sat_count_out += popcount(sat_flags_out).
//    - The counter saturates at all-ones and never wraps.
//    - clear_count_in=1 loads 0 and wins over a same-cycle increment.
//  SAT_COUNTER_EN undefined:
//    - sat_count_out is tied to 0, clear_count_in is ignored, and no counter
//      logic is synthesised. sat_flags_out is still produced.
// STRUCTURE
//  - Package nn_quant_pkg holds:
//    - typedefs acc_t (logic signed [IN_WIDTH-1:0]) and act_t (signed [OUT_WIDTH-1:0]);
//    - constants ACT_MAX and ACT_MIN;
//    - function sat_round_shift() shared with other quantising blocks.
//  - Sub-module requant_lane: one lane's S1/S2 datapath, instantiated NUM_CHANNELS
//    times via generate.
//  - Handshake control and the counter live in the top module.
// TESTING
//  Defaults, SAT_COUNTER_EN defined, ready_in=1 unless stated.
//  1. shift=0, all lanes 0x7FFFFFFF / 0x80000000
//     -> 0x7FFF / 0x8000, flags all 1, valid_out exactly 2 cycles after accept.
//  2. shift=4, lane0=24, lane1=-24, lane2=0x0007FFF0, lane3=0xFFF80000
//     -> 0x0002, 0xFFFF, 0x7FFF (flag=0), 0x8000 (flag=0).
//  3. shift=8, lane0=0x007FFF80 -> 0x7FFF, flag0=1 (round carry saturates);
//     shift_in=31 with lane1=-1 -> 0x0000.
//  4. Continuous valid_in beats tagged 1..8, ready_in low for 3 cycles mid-stream
//     -> ready_out drops while 2 beats are held; outputs 1..8 in order, no gaps or
//     duplicates; data_out stable during stall.
//  5. 3 beats with all 4 lanes saturating -> sat_count_out=12. Then clear_count_in=1
//     in the same cycle as a saturating handshake -> 0. Then count from 0xFFFE + 4
//     -> holds at 0xFFFF.
//  6. Assert rst_n_in=0 with both stages full
//     -> next edge: valid_out=0, data_out=0, sat_count_out=0, ready_out=1;
//     no stale beat emitted after release.

Source files
------------

// File: rtl/nn_quant_pkg.sv
// Shared quantisation types and helpers for the neuron datapath.
// Lane widths live here so every quantising block agrees on acc_t/act_t.
package nn_quant_pkg;

  localparam int IN_WIDTH        = 32;
  localparam int OUT_WIDTH       = 16;
  localparam int SHIFT_ARG_WIDTH = 8;

  typedef logic signed [IN_WIDTH-1:0]  acc_t;
  typedef logic signed [OUT_WIDTH-1:0] act_t;
  // One extra bit so the rounding bias can never wrap the accumulator.
  typedef logic signed [IN_WIDTH:0]    wide_t;
  typedef logic [SHIFT_ARG_WIDTH-1:0]  shamt_t;

  localparam act_t ACT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam act_t ACT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    act_t value;
    logic sat;
  } sat_result_t;

  // Shifting by more than IN_WIDTH-1 adds nothing, so cap it there.
  function automatic shamt_t clamp_shift(input shamt_t sh);
    shamt_t res;
    if (sh > shamt_t'(IN_WIDTH - 1)) res = shamt_t'(IN_WIDTH - 1);
    else                             res = sh;
    return res;
  endfunction

  // Arithmetic right shift with round-half-up, evaluated one bit wider.
  function automatic wide_t round_shift(input acc_t x, input shamt_t sh);
    shamt_t s;
    wide_t  ext;
    wide_t  bias;
    wide_t  res;
    s   = clamp_shift(sh);
    ext = wide_t'(x);
    if (s == '0) begin
      res = ext;
    end else begin
      bias = wide_t'(1) << (s - shamt_t'(1));
      res  = (ext + bias) >>> s;
    end
    return res;
  endfunction

  // Clip a rounded value into the signed activation range.
  function automatic sat_result_t saturate(input wide_t r);
    sat_result_t res;
    if (r > wide_t'(ACT_MAX)) begin
      res.value = ACT_MAX;
      res.sat   = 1'b1;
    end else if (r < wide_t'(ACT_MIN)) begin
      res.value = ACT_MIN;
      res.sat   = 1'b1;
    end else begin
      res.value = act_t'(r[OUT_WIDTH-1:0]);
      res.sat   = 1'b0;
    end
    return res;
  endfunction

  // Single-cycle combination for blocks that do not pipeline the two steps.
  function automatic sat_result_t sat_round_shift(input acc_t x, input shamt_t sh);
    return saturate(round_shift(x, sh));
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One requantiser lane: S1 holds the rounded/shifted value, S2 holds the
// saturated activation and its flag. Load enables come from the shared
// handshake control in the top level.
module requant_lane
  import nn_quant_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   s1_load,
  input  logic   s2_load,
  input  acc_t   acc,
  input  shamt_t shift,
  output act_t   act,
  output logic   sat
);

  wide_t       s1_rounded;
  sat_result_t s2_next;

  // S1: capture the shifted and rounded accumulator when a beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n)       s1_rounded <= '0;
    else if (s1_load) s1_rounded <= round_shift(acc, shift);
  end

  // Saturation of the S1 value feeding the output register.
  always_comb begin
    s2_next = saturate(s1_rounded);
  end

  // S2: output registers, held while the downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act <= '0;
      sat <= 1'b0;
    end else if (s2_load) begin
      act <= s2_next.value;
      sat <= s2_next.sat;
    end
  end

endmodule

// File: rtl/saturating_requantizer.sv
// Multi-channel saturating requantiser: per-lane shift/round/saturate in a
// two-stage valid/ready pipeline, with an optional saturation event counter
// enabled by defining SAT_COUNTER_EN.
module saturating_requantizer
  import nn_quant_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SHIFT_WIDTH  = 5,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           valid_in,
  output logic                           ready_out,
  input  logic [NUM_CHANNELS*IN_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0]         shift_in,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic [NUM_CHANNELS*OUT_WIDTH-1:0] data_out,
  output logic [NUM_CHANNELS-1:0]        sat_flags_out,
  input  logic                           clear_count_in,
  output logic [COUNT_WIDTH-1:0]         sat_count_out
);

  logic   s1_valid;
  logic   s2_valid;
  logic   s1_take;
  logic   s2_take;
  logic   accept;
  logic   s2_load;
  shamt_t shift_clamped;

  // Stage enables: a stage takes a beat when empty or when its successor drains.
  always_comb begin
    s2_take = !s2_valid || ready_in;
    s1_take = !s1_valid || s2_take;
    accept  = valid_in && s1_take;
    s2_load = s1_valid && s2_take;
  end

  assign ready_out = s1_take;
  assign valid_out = s2_valid;

  // Cap the runtime shift before it reaches the lanes.
  always_comb begin
    if (32'(shift_in) > 32'(IN_WIDTH - 1)) shift_clamped = shamt_t'(IN_WIDTH - 1);
    else                                   shift_clamped = shamt_t'(shift_in);
  end

  // Stage valid bits; reset drops any in-flight beats.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_take) s1_valid <= valid_in;
      if (s2_take) s2_valid <= s1_valid;
    end
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
    requant_lane u_lane (
      .clk     (clk_in),
      .rst_n   (rst_n_in),
      .s1_load (accept),
      .s2_load (s2_load),
      .acc     (data_in[k*IN_WIDTH +: IN_WIDTH]),
      .shift   (shift_clamped),
      .act     (data_out[k*OUT_WIDTH +: OUT_WIDTH]),
      .sat     (sat_flags_out[k])
    );
  end

`ifdef SAT_COUNTER_EN
  localparam int CW1 = COUNT_WIDTH + 1;

  logic                   out_fire;
  logic [COUNT_WIDTH:0]   flag_total;
  logic [COUNT_WIDTH:0]   count_sum;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_next;

  // Popcount of the outgoing flags added to the counter, sticking at all-ones.
  always_comb begin
    out_fire   = s2_valid && ready_in;
    flag_total = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      flag_total = flag_total + CW1'(sat_flags_out[k]);
    end
    count_sum = {1'b0, count_q} + flag_total;
    if (count_sum[COUNT_WIDTH]) count_next = '1;
    else                        count_next = count_sum[COUNT_WIDTH-1:0];
  end

  // Saturation event counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)           count_q <= '0;
    else if (clear_count_in) count_q <= '0;
    else if (out_fire)       count_q <= count_next;
  end

  assign sat_count_out = count_q;
`else
  logic unused_clear;
  assign unused_clear  = clear_count_in;
  assign sat_count_out = '0;
`endif

endmodule

// File: tb/tb_saturating_requantizer.sv
// Self-checking bench for saturating_requantizer. Counter expectations follow
// SAT_COUNTER_EN so the bench works in either build.
module tb_saturating_requantizer;

  localparam int NC = 4;
  localparam int IW = 32;
  localparam int OW = 16;
`ifdef SAT_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n_in;
  logic            valid_in;
  logic            ready_out;
  logic [NC*IW-1:0] data_in;
  logic [4:0]      shift_in;
  logic            valid_out;
  logic            ready_in;
  logic [NC*OW-1:0] data_out;
  logic [NC-1:0]   sat_flags_out;
  logic            clear_count_in;
  logic [15:0]     sat_count_out;

  typedef struct packed {
    logic [NC*OW-1:0] data;
    logic [NC-1:0]    flags;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   out_count = 0;

  localparam logic [127:0] SAT_ALL = {32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  localparam logic [127:0] SAT_TWO = {32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000000};

  saturating_requantizer dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .data_in        (data_in),
    .shift_in       (shift_in),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .data_out       (data_out),
    .sat_flags_out  (sat_flags_out),
    .clear_count_in (clear_count_in),
    .sat_count_out  (sat_count_out)
  );

  always #5 clk = ~clk;

  // Reference lane: round-half-up shift in 64-bit arithmetic, then clip.
  function automatic logic [16:0] model_lane(input logic [31:0] x, input int sh);
    longint xv;
    longint r;
    int     s;
    xv = longint'($signed(x));
    s  = (sh > 31) ? 31 : sh;
    if (s == 0) r = xv;
    else        r = (xv + (longint'(1) << (s - 1))) >>> s;
    if (r > 32767)       return {1'b1, 16'h7FFF};
    else if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic exp_t model_beat(input logic [127:0] d, input int sh);
    exp_t        e;
    logic [16:0] m;
    for (int k = 0; k < NC; k++) begin
      m = model_lane(d[k*IW +: IW], sh);
      e.data[k*OW +: OW] = m[15:0];
      e.flags[k]         = m[16];
    end
    return e;
  endfunction

  // Scoreboard: compare every output handshake against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n_in && valid_out && ready_in) begin
      out_count++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL scoreboard_unexpected got data=%h flags=%b expected no output", data_out, sat_flags_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (data_out !== e.data || sat_flags_out !== e.flags) begin
          failures++;
          $display("[TB] FAIL scoreboard got data=%h flags=%b expected data=%h flags=%b",
                   data_out, sat_flags_out, e.data, e.flags);
        end
      end
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic [4:0] sh);
    bit got;
    got      = 1'b0;
    valid_in = 1'b1;
    data_in  = d;
    shift_in = sh;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_out === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (got) sb_q.push_back(model_beat(d, int'(sh)));
    else begin
      failures++;
      $display("[TB] FAIL send_timeout ready_out=%b expected 1", ready_out);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout pending=%0d expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1; clear_count_in = 1'b0;
    data_in = '0; shift_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b expected=0", valid_out); end
    if (data_out !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h expected=0", data_out); end
    if (sat_flags_out !== '0) begin failures++; $display("[TB] FAIL reset_flags got=%b expected=0", sat_flags_out); end
    if (sat_count_out !== '0) begin failures++; $display("[TB] FAIL reset_count got=%h expected=0", sat_count_out); end
    if (ready_out !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b expected=1", ready_out); end
    rst_n_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate_shift0();
    send_beat(SAT_ALL, 5'd0);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL latency_early got=%b expected=0", valid_out); end
    @(negedge clk);
    checks += 3;
    if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL latency_two got=%b expected=1", valid_out); end
    if (data_out !== 64'h8000_7FFF_8000_7FFF) begin failures++; $display("[TB] FAIL shift0_data got=%h expected=80007fff80007fff", data_out); end
    if (sat_flags_out !== 4'hF) begin failures++; $display("[TB] FAIL shift0_flags got=%b expected=1111", sat_flags_out); end
    wait_drain();
  endtask

  task automatic test_round_shift();
    send_beat({32'hFFF80000, 32'h0007FFF0, 32'hFFFFFFE8, 32'h00000018}, 5'd4);
    @(negedge clk); @(negedge clk);
    checks += 2;
    if (data_out !== 64'h8000_7FFF_FFFF_0002) begin failures++; $display("[TB] FAIL shift4_data got=%h expected=80007fffffff0002", data_out); end
    if (sat_flags_out !== 4'h0) begin failures++; $display("[TB] FAIL shift4_flags got=%b expected=0000", sat_flags_out); end
    wait_drain();
    send_beat({32'h0, 32'h0, 32'h0, 32'h007FFF80}, 5'd8);
    @(negedge clk); @(negedge clk);
    checks += 2;
    if (data_out !== 64'h0000_0000_0000_7FFF) begin failures++; $display("[TB] FAIL round_carry_data got=%h expected=0000000000007fff", data_out); end
    if (sat_flags_out !== 4'b0001) begin failures++; $display("[TB] FAIL round_carry_flags got=%b expected=0001", sat_flags_out); end
    wait_drain();
    send_beat({32'h40000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF}, 5'd31);
    @(negedge clk); @(negedge clk);
    checks += 2;
    if (data_out !== 64'h0001_FFFF_0000_0001) begin failures++; $display("[TB] FAIL shift31_data got=%h expected=0001ffff00000001", data_out); end
    if (sat_flags_out !== 4'h0) begin failures++; $display("[TB] FAIL shift31_flags got=%b expected=0000", sat_flags_out); end
    wait_drain();
    checks++;
    if (sat_count_out !== (CNT_EN ? 16'd5 : 16'd0)) begin
      failures++; $display("[TB] FAIL count_after_basic got=%h expected=%h", sat_count_out, CNT_EN ? 16'd5 : 16'd0);
    end
  endtask

  task automatic test_back_to_back();
    int   start_count;
    exp_t exp3;
    exp3        = model_beat({32'(9), 32'(-3), 32'(300), 32'(3)}, 0);
    start_count = out_count;
    ready_in    = 1'b1;
    fork
      begin
        for (int t = 1; t <= 8; t++) begin
          send_beat({32'(t * 3), 32'(-t), 32'(t * 100), 32'(t)}, 5'd0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checks += 3;
          if (ready_out !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready cycle=%0d got=%b expected=0", c, ready_out); end
          if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid cycle=%0d got=%b expected=1", c, valid_out); end
          if (data_out !== exp3.data) begin failures++; $display("[TB] FAIL stall_data cycle=%0d got=%h expected=%h", c, data_out, exp3.data); end
          @(posedge clk);
        end
        #1;
        ready_in = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (out_count - start_count != 8) begin
      failures++; $display("[TB] FAIL stream_count got=%0d expected=8", out_count - start_count);
    end
  endtask

  task automatic test_counter();
    ready_in       = 1'b1;
    clear_count_in = 1'b1;
    @(posedge clk);
    #1;
    clear_count_in = 1'b0;
    checks++;
    if (sat_count_out !== 16'd0) begin failures++; $display("[TB] FAIL count_clear got=%h expected=0", sat_count_out); end
    for (int i = 0; i < 3; i++) send_beat(SAT_ALL, 5'd0);
    wait_drain();
    checks++;
    if (sat_count_out !== (CNT_EN ? 16'd12 : 16'd0)) begin
      failures++; $display("[TB] FAIL count_twelve got=%h expected=%h", sat_count_out, CNT_EN ? 16'd12 : 16'd0);
    end
    send_beat(SAT_ALL, 5'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) break;
    end
    clear_count_in = 1'b1;
    @(posedge clk);
    #1;
    clear_count_in = 1'b0;
    checks += 2;
    if (sat_count_out !== 16'd0) begin failures++; $display("[TB] FAIL clear_wins got=%h expected=0", sat_count_out); end
    if (sb_q.size() != 0) begin failures++; $display("[TB] FAIL clear_handshake pending=%0d expected 0", sb_q.size()); end
    for (int i = 0; i < 16383; i++) send_beat(SAT_ALL, 5'd0);
    send_beat(SAT_TWO, 5'd0);
    wait_drain();
    checks++;
    if (sat_count_out !== (CNT_EN ? 16'hFFFE : 16'd0)) begin
      failures++; $display("[TB] FAIL count_fffe got=%h expected=%h", sat_count_out, CNT_EN ? 16'hFFFE : 16'd0);
    end
    for (int r = 0; r < 2; r++) begin
      send_beat(SAT_ALL, 5'd0);
      wait_drain();
      checks++;
      if (sat_count_out !== (CNT_EN ? 16'hFFFF : 16'd0)) begin
        failures++; $display("[TB] FAIL count_hold round=%0d got=%h expected=%h", r, sat_count_out, CNT_EN ? 16'hFFFF : 16'd0);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    ready_in = 1'b0;
    send_beat(SAT_ALL, 5'd0);
    send_beat({32'd4, 32'd3, 32'd2, 32'd1}, 5'd0);
    valid_in = 1'b1;
    data_in  = {32'd8, 32'd7, 32'd6, 32'd5};
    @(negedge clk);
    checks += 2;
    if (ready_out !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b expected=0", ready_out); end
    if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL full_valid got=%b expected=1", valid_out); end
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    checks += 4;
    if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid got=%b expected=0", valid_out); end
    if (data_out !== '0) begin failures++; $display("[TB] FAIL mid_reset_data got=%h expected=0", data_out); end
    if (sat_count_out !== '0) begin failures++; $display("[TB] FAIL mid_reset_count got=%h expected=0", sat_count_out); end
    if (ready_out !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_ready got=%b expected=1", ready_out); end
    sb_q.delete();
    rst_n_in = 1'b1;
    ready_in = 1'b1;
    seen     = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid_out !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("[TB] FAIL stale_beat got=%0d expected=0", seen); end
  endtask

  initial begin
    test_reset();
    test_saturate_shift0();
    test_round_shift();
    test_back_to_back();
    test_counter();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
